nitc_mem_responder: RTL and testbench
=====================================

# nitc_mem_responder

Memory responder for the NITC RISC24 multicycle core: the slave end of the processor's memory port, serving 16-bit word reads and writes with a valid/ready request handshake and a single-cycle response strobe. It replaces the zero-latency combinational memory array with a registered, parameterisable-latency memory. The processor's control FSM can then stall on `rsp_valid` instead of assuming same-cycle data.

## Interface
Parameters:
- `DEPTH`, 32: number of 16-bit words. Valid addresses are 0..DEPTH-1.
- `LATENCY`, 2: wait cycles between acceptance and the access edge. Range 0..15.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  1  initiator has a request; held until accepted.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  16  word address.
- `req_wdata`  in  16  write data.
- `req_ready`  out  1  responder can accept; handshake is `req_valid & req_ready` at a rising edge.
- `rsp_valid`  out  1  one-cycle pulse: read data valid, or write completed.
- `rsp_rdata`  out  16  read data. Registered; holds until the next response.
- `rsp_err`  out  1  qualified by `rsp_valid`; address was >= DEPTH.
- `busy`  out  1  high whenever state != IDLE.

## Operation
- States: IDLE, WAIT, RESP.
- **IDLE**
  - `req_ready`=1.
  - On handshake: capture `req_we`, `req_addr` and `req_wdata` into internal registers and load `cnt`=LATENCY.
  - If LATENCY=0, go to RESP and perform the access on that same edge. Otherwise go to WAIT.
- **WAIT**
  - `req_ready`=0; `cnt` decrements each cycle.
  - When `cnt`=1, the next edge performs the access and moves to RESP.
- **Access edge**
  - Write, in range: `mem[addr]` <= captured wdata; `rsp_rdata` unchanged.
  - Read, in range: `rsp_rdata` <= `mem[addr]`.
  - Out of range: no array write; `rsp_rdata` <= 0; `rsp_err` <= 1.
  - In-range accesses clear `rsp_err`.
- **RESP**
  - `rsp_valid`=1 and `req_ready`=0 for exactly one cycle, then return to IDLE.
- Request fields are sampled only at the handshake. Later changes have no effect on the in-flight access.
- `req_valid` while `req_ready`=0 is ignored; the initiator must hold the request.
- Address compare uses the full 16 bits; there is no wrap or aliasing.
- Read after write to the same address, issued after the write's `rsp_valid`, returns the new data.
- Memory array contents are not affected by reset and are uninitialised at power-up. The bench preloads the array via hierarchical access.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `busy`=0, `cnt`=0. All apply asynchronously, on assertion of `reset`.
- Handshake at edge T:
  - access edge = T+LATENCY;
  - `rsp_valid` is high between edges T+LATENCY and T+LATENCY+1;
  - `req_ready` returns high after edge T+LATENCY+1.
- Maximum throughput: one request per LATENCY+2 cycles.
- Reset mid-operation: the in-flight request is dropped. A write whose access edge has not occurred is not committed. No `rsp_valid` is produced for it.
- Reset asserted on the access edge: the reset wins and the write is not committed.
- A `rsp_valid` pulse in progress is truncated by reset.
- Handshake on the edge leaving RESP cannot occur, because `req_ready`=0 in RESP. The next acceptance is at the earliest edge T+LATENCY+2.

## Test plan
All scenarios use DEPTH=32, LATENCY=2.
- **Reset values:** assert reset mid-cycle with no clock edge -> all outputs at reset values immediately.
- **Write then read:** write addr 5 data 16'hA5C3 accepted at edge T -> `rsp_valid` pulse after edge T+2, `rsp_err`=0. Then read addr 5 -> `rsp_rdata`=16'hA5C3 during its `rsp_valid`; `rsp_rdata` holds 16'hA5C3 afterwards.
- **Back-to-back:** `req_valid` held high for 3 requests (write 16'h0003 to addr 1, read addr 1, read addr 2 preloaded with 16'hFFFF):
  - acceptances exactly 4 cycles apart;
  - responses: ack, 16'h0003, 16'hFFFF;
  - `req_ready` low for 3 cycles after each acceptance.
- **Out of range:** write addr 32 data 16'h1234, then read addr 40 -> both responses have `rsp_err`=1, read `rsp_rdata`=0, and mem[0] is unchanged. A following read of addr 0 has `rsp_err`=0.
- **Reset mid-write:** write addr 7 data 16'hBEEF (mem[7] preloaded 16'h0001), assert reset one cycle after acceptance -> no `rsp_valid`, and a read of addr 7 after reset returns 16'h0001.
- **Boundary and stability:** with LATENCY=0, a read of addr 31 -> `rsp_valid` in the cycle right after acceptance. Changing `req_addr`/`req_wdata` during WAIT -> no effect on the result.

Source files
------------

// File: rtl/nitc_mem_responder.sv
// rtl/nitc_mem_responder.sv - registered 16-bit word memory slave with parameterisable access latency
module nitc_mem_responder #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [15:0] mem [DEPTH];

    logic          access;
    logic          acc_we;
    logic [15:0]   acc_addr;
    logic [15:0]   acc_wdata;
    logic          acc_in_range;
    logic [AW-1:0] acc_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        access    = 1'b0;
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 4'(LATENCY);
                    // Zero latency: the access uses the live request on the accepting edge.
                    if (LATENCY == 0) begin
                        state_d   = S_RESP;
                        access    = 1'b1;
                        acc_we    = req_we;
                        acc_addr  = req_addr;
                        acc_wdata = req_wdata;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    access  = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        acc_in_range = ({1'b0, acc_addr} < 17'(DEPTH));
        acc_idx      = acc_addr[AW-1:0];
        if (access) begin
            if (!acc_in_range) begin
                rdata_d = '0;
                err_d   = 1'b1;
            end else begin
                err_d = 1'b0;
                if (!acc_we) rdata_d = mem[acc_idx];
            end
        end
    end

    // Array is never reset; a reset coinciding with the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (access && acc_we && acc_in_range && !reset) mem[acc_idx] <= acc_wdata;
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
endmodule

// File: tb/tb_nitc_mem_responder.sv
// tb/tb_nitc_mem_responder.sv - randomized self-checking bench for nitc_mem_responder
module tb_nitc_mem_responder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req_valid, req_we, req_ready, rsp_valid, rsp_err, busy;
    logic [15:0] req_addr, req_wdata, rsp_rdata;
    logic        l0_req_valid, l0_req_we, l0_req_ready, l0_rsp_valid, l0_rsp_err, l0_busy;
    logic [15:0] l0_req_addr, l0_req_wdata, l0_rsp_rdata;

    nitc_mem_responder #(.DEPTH(32), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    nitc_mem_responder #(.DEPTH(32), .LATENCY(0)) dut_l0 (
        .clk(clk), .reset(reset), .req_valid(l0_req_valid), .req_we(l0_req_we),
        .req_addr(l0_req_addr), .req_wdata(l0_req_wdata), .req_ready(l0_req_ready),
        .rsp_valid(l0_rsp_valid), .rsp_rdata(l0_rsp_rdata), .rsp_err(l0_rsp_err), .busy(l0_busy)
    );

    int n_pass = 0;
    int n_checks = 0;
    logic [15:0] model_mem [32];
    logic [15:0] model_rdata;

    // Reference: apply one request to the model and report the expected response.
    task automatic model_access(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                                output logic [15:0] erd, output logic eerr);
        if (addr < 16'd32) begin
            eerr = 1'b0;
            if (we) model_mem[addr[4:0]] = wd;
            else    model_rdata = model_mem[addr[4:0]];
        end else begin
            eerr = 1'b1;
            model_rdata = 16'h0000;
        end
        erd = model_rdata;
    endtask

    task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                         output int acc_c, output int rsp_c, output logic [15:0] rd,
                         output logic er, output bit to);
        int k;
        to = 1'b0; acc_c = -1; rsp_c = -1; rd = 'x; er = 1'bx;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        k = 0;
        while (!req_ready && k < 50) begin @(negedge clk); k++; end
        if (!req_ready) begin to = 1'b1; req_valid = 1'b0; return; end
        @(negedge clk);
        acc_c = cyc;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
        k = 0;
        while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
        if (!rsp_valid) begin to = 1'b1; return; end
        rsp_c = cyc; rd = rsp_rdata; er = rsp_err;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, busy} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
            $display("FAIL reset_outputs: got %b_%b_%h_%b_%b want 1_0_0000_0_0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, busy);
        end else n_pass++;
        n_checks++;
        if (dut.cnt_q !== 4'd0) $display("FAIL reset_cnt: got %0d want 0", dut.cnt_q);
        else n_pass++;
        n_checks++;
        if ({l0_req_ready, l0_rsp_valid, l0_rsp_rdata, l0_rsp_err, l0_busy} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0})
            $display("FAIL reset_outputs_l0: got %b_%b_%h_%b_%b want 1_0_0000_0_0",
                     l0_req_ready, l0_rsp_valid, l0_rsp_rdata, l0_rsp_err, l0_busy);
        else n_pass++;
        model_rdata = 16'h0000;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        int a, r; logic [15:0] rd, erd; logic er, eer; bit to;
        issue(1'b1, 16'd5, 16'hA5C3, a, r, rd, er, to);
        model_access(1'b1, 16'd5, 16'hA5C3, erd, eer);
        n_checks++;
        if (to || r - a != 2 || er !== 1'b0)
            $display("FAIL wr_ack: timeout=%0d latency=%0d err=%b want latency 2 err 0", to, r - a, er);
        else n_pass++;
        issue(1'b0, 16'd5, 16'h0000, a, r, rd, er, to);
        model_access(1'b0, 16'd5, 16'h0000, erd, eer);
        n_checks++;
        if (to || r - a != 2 || rd !== erd || er !== eer)
            $display("FAIL rd_after_wr: timeout=%0d latency=%0d data=%h err=%b want 2 %h %b", to, r - a, rd, er, erd, eer);
        else n_pass++;
        @(negedge clk); @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 16'hA5C3)
            $display("FAIL rdata_hold: valid=%b data=%h want 0 a5c3", rsp_valid, rsp_rdata);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic        we_t [3];
        logic [15:0] ad_t [3];
        logic [15:0] wd_t [3];
        logic [15:0] rdv[$];
        logic        erv[$];
        int          accs[$];
        int          runs[$];
        int          run, idx;
        bit          adv;
        logic [15:0] erd; logic eer;
        we_t[0] = 1'b1; ad_t[0] = 16'd1; wd_t[0] = 16'h0003;
        we_t[1] = 1'b0; ad_t[1] = 16'd1; wd_t[1] = 16'($urandom);
        we_t[2] = 1'b0; ad_t[2] = 16'd2; wd_t[2] = 16'($urandom);
        dut.mem[2] = 16'hFFFF; model_mem[2] = 16'hFFFF;
        run = 0; idx = 0; adv = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we_t[0]; req_addr = ad_t[0]; req_wdata = wd_t[0];
        for (int c = 0; c < 40 && rdv.size() < 3; c++) begin
            if (adv) begin
                adv = 1'b0;
                if (idx < 3) begin req_we = we_t[idx]; req_addr = ad_t[idx]; req_wdata = wd_t[idx]; end
                else req_valid = 1'b0;
            end
            if (rsp_valid) begin rdv.push_back(rsp_rdata); erv.push_back(rsp_err); end
            if (!req_ready) run++;
            else if (run > 0) begin runs.push_back(run); run = 0; end
            if (req_ready && req_valid) begin accs.push_back(cyc + 1); idx++; adv = 1'b1; end
            @(negedge clk);
        end
        req_valid = 1'b0;
        if (req_ready && run > 0) runs.push_back(run);
        n_checks++;
        if (accs.size() != 3 || rdv.size() != 3 || runs.size() != 3) begin
            $display("FAIL b2b_counts: accepts=%0d responses=%0d ready_gaps=%0d want 3 3 3",
                     accs.size(), rdv.size(), runs.size());
            return;
        end else n_pass++;
        for (int i = 0; i < 3; i++) begin
            model_access(we_t[i], ad_t[i], wd_t[i], erd, eer);
            n_checks++;
            if (rdv[i] !== erd || erv[i] !== eer)
                $display("FAIL b2b_rsp%0d: data=%h err=%b want %h %b", i, rdv[i], erv[i], erd, eer);
            else n_pass++;
            n_checks++;
            if (runs[i] != 3) $display("FAIL b2b_ready_low%0d: got %0d cycles want 3", i, runs[i]);
            else n_pass++;
        end
        for (int i = 1; i < 3; i++) begin
            n_checks++;
            if (accs[i] - accs[i-1] != 4)
                $display("FAIL b2b_spacing%0d: got %0d want 4", i, accs[i] - accs[i-1]);
            else n_pass++;
        end
    endtask

    task automatic test_out_of_range();
        int a, r; logic [15:0] rd, erd; logic er, eer; bit to;
        logic [15:0] addrs [3];
        logic        wes   [3];
        addrs[0] = 16'd32; wes[0] = 1'b1;
        addrs[1] = 16'd40; wes[1] = 1'b0;
        addrs[2] = 16'd0;  wes[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(wes[i], addrs[i], 16'h1234, a, r, rd, er, to);
            model_access(wes[i], addrs[i], 16'h1234, erd, eer);
            n_checks++;
            if (to || r - a != 2 || er !== eer || (!wes[i] && rd !== erd))
                $display("FAIL oor%0d: timeout=%0d latency=%0d data=%h err=%b want 2 %h %b",
                         i, to, r - a, rd, er, erd, eer);
            else n_pass++;
        end
        n_checks++;
        if (dut.mem[0] !== model_mem[0]) $display("FAIL oor_mem0: got %h want %h", dut.mem[0], model_mem[0]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        int a, r; logic [15:0] rd, erd; logic er, eer; bit to;
        int seen;
        dut.mem[7] = 16'h0001; model_mem[7] = 16'h0001;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'd7; req_wdata = 16'hBEEF;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, busy} !== 3'b100)
            $display("FAIL midrst_async: ready/valid/busy=%b%b%b want 100", req_ready, rsp_valid, busy);
        else n_pass++;
        model_rdata = 16'h0000;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) seen++;
            @(negedge clk);
        end
        n_checks++;
        if (seen != 0) $display("FAIL midrst_no_rsp: got %0d pulses want 0", seen);
        else n_pass++;
        issue(1'b0, 16'd7, 16'h0000, a, r, rd, er, to);
        model_access(1'b0, 16'd7, 16'h0000, erd, eer);
        n_checks++;
        if (to || rd !== erd || er !== eer)
            $display("FAIL midrst_mem7: timeout=%0d data=%h err=%b want %h %b", to, rd, er, erd, eer);
        else n_pass++;
    endtask

    task automatic test_random();
        int a, r; logic [15:0] rd, erd, ad, wd; logic er, eer, we; bit to;
        for (int i = 0; i < 24; i++) begin
            we = 1'($urandom);
            ad = 16'($urandom_range(0, 39));
            wd = 16'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(we, ad, wd, a, r, rd, er, to);
            model_access(we, ad, wd, erd, eer);
            n_checks++;
            if (to || r - a != 2 || rd !== erd || er !== eer)
                $display("FAIL rand%0d we=%b addr=%0d: timeout=%0d latency=%0d data=%h err=%b want 2 %h %b",
                         i, we, ad, to, r - a, rd, er, erd, eer);
            else n_pass++;
        end
    endtask

    task automatic test_latency0();
        logic [15:0] wd;
        logic [15:0] ads [3];
        logic        wes [3];
        logic [15:0] exp_d [3];
        logic        exp_e [3];
        wd = 16'($urandom);
        ads[0] = 16'd31; wes[0] = 1'b1; exp_d[0] = 16'h0000; exp_e[0] = 1'b0;
        ads[1] = 16'd31; wes[1] = 1'b0; exp_d[1] = wd;       exp_e[1] = 1'b0;
        ads[2] = 16'd32; wes[2] = 1'b0; exp_d[2] = 16'h0000; exp_e[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            l0_req_valid = 1'b1; l0_req_we = wes[i]; l0_req_addr = ads[i]; l0_req_wdata = wd;
            @(negedge clk);
            l0_req_valid = 1'b0;
            l0_req_we = 1'($urandom); l0_req_addr = 16'($urandom); l0_req_wdata = 16'($urandom);
            n_checks++;
            if (l0_rsp_valid !== 1'b1 || l0_rsp_err !== exp_e[i] || (!wes[i] && l0_rsp_rdata !== exp_d[i]))
                $display("FAIL lat0_%0d: valid=%b data=%h err=%b want 1 %h %b",
                         i, l0_rsp_valid, l0_rsp_rdata, l0_rsp_err, exp_d[i], exp_e[i]);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (l0_rsp_valid !== 1'b0 || l0_req_ready !== 1'b1)
                $display("FAIL lat0_pulse%0d: valid=%b ready=%b want 0 1", i, l0_rsp_valid, l0_req_ready);
            else n_pass++;
        end
    endtask

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        l0_req_valid = 1'b0; l0_req_we = 1'b0; l0_req_addr = '0; l0_req_wdata = '0;
        for (int i = 0; i < 32; i++) begin
            model_mem[i] = 16'($urandom);
            dut.mem[i] = model_mem[i];
            dut_l0.mem[i] = 16'($urandom);
        end
        test_reset();
        test_write_read();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_write();
        test_random();
        test_latency0();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
